// File: rtl/multiply_sum_pipe.sv
// Three-stage signed multiply-sum pipeline: out = bias + sum(coef[k]*data[k]), valid/ready flow control.
// Define MULTIPLY_SUM_PIPE_SATURATE_EN to clamp sum_o on overflow instead of wrapping.
module multiply_sum_pipe #(
    parameter int NUM_TAPS = 3,
    parameter int DATA_W   = 32,
    parameter int COEF_W   = 8,
    parameter int BIAS_W   = 16,
    parameter int OUT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_TAPS*DATA_W-1:0]   data_i,
    input  logic [BIAS_W-1:0]            bias_i,
    input  logic                         coef_we,
    input  logic [2:0]                   coef_idx,
    input  logic [COEF_W-1:0]            coef_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             sum_o,
    output logic                         ovf_o,
    output logic                         busy_o
);

    localparam int ACC_W    = DATA_W + COEF_W + $clog2(NUM_TAPS) + 1;
    localparam int NUM_PART = (NUM_TAPS + 1) / 2;

    logic signed [COEF_W-1:0] coef   [NUM_TAPS];
    logic signed [ACC_W-1:0]  prod_c [NUM_TAPS];
    logic signed [ACC_W-1:0]  prod   [NUM_TAPS];
    logic signed [ACC_W-1:0]  bias_r;
    logic signed [ACC_W-1:0]  part_c [NUM_PART];
    logic signed [ACC_W-1:0]  part   [NUM_PART];
    logic signed [ACC_W-1:0]  r;
    logic [OUT_W-1:0]         sum_c;
    logic                     ovf_c;
    logic                     v1;
    logic                     v2;
    logic                     advance;

    always_comb begin
        advance  = ~(out_valid & ~out_ready);
        in_ready = advance;
        busy_o   = v1 | v2 | out_valid;
    end

    // Writes land regardless of stall; a sample accepted on the same edge sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) coef[k] <= '0;
        end else if (coef_we) begin
            for (int k = 0; k < NUM_TAPS; k++)
                if (coef_idx == 3'(k)) coef[k] <= coef_data;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++)
            prod_c[k] = ACC_W'($signed(data_i[k*DATA_W +: DATA_W])) * ACC_W'(coef[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            bias_r <= '0;
            for (int k = 0; k < NUM_TAPS; k++) prod[k] <= '0;
        end else if (advance) begin
            v1     <= in_valid;
            bias_r <= ACC_W'($signed(bias_i));
            for (int k = 0; k < NUM_TAPS; k++) prod[k] <= prod_c[k];
        end
    end

    genvar j;
    generate
        for (j = 0; j < NUM_PART; j++) begin : g_pair
            if (2*j + 1 < NUM_TAPS) begin : g_two
                assign part_c[j] = prod[2*j] + prod[2*j+1];
            end else begin : g_one
                assign part_c[j] = prod[2*j];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
            for (int p = 0; p < NUM_PART; p++) part[p] <= '0;
        end else if (advance) begin
            v2 <= v1;
            for (int p = 0; p < NUM_PART; p++)
                part[p] <= (p == 0) ? part_c[p] + bias_r : part_c[p];
        end
    end

    always_comb begin
        r = '0;
        for (int p = 0; p < NUM_PART; p++) r = r + part[p];
    end

    // Result fits OUT_W exactly when all bits from the OUT_W sign bit upward agree.
    generate
        if (ACC_W > OUT_W) begin : g_narrow
            assign ovf_c = ~((&r[ACC_W-1:OUT_W-1]) | ~(|r[ACC_W-1:OUT_W-1]));
`ifdef MULTIPLY_SUM_PIPE_SATURATE_EN
            assign sum_c = ~ovf_c ? r[OUT_W-1:0] :
                           r[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`else
            assign sum_c = r[OUT_W-1:0];
`endif
        end else begin : g_wide
            assign ovf_c = 1'b0;
            assign sum_c = OUT_W'(r);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum_o     <= '0;
            ovf_o     <= 1'b0;
        end else if (advance) begin
            out_valid <= v2;
            sum_o     <= sum_c;
            ovf_o     <= ovf_c;
        end
    end

endmodule

// File: tb/tb_multiply_sum_pipe.sv
// Directed bench for multiply_sum_pipe; honours MULTIPLY_SUM_PIPE_SATURATE_EN for overflow expectations.
module tb_multiply_sum_pipe;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int BW = 16;
    localparam int OW = 32;
`ifdef MULTIPLY_SUM_PIPE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] data_i;
    logic [BW-1:0]   bias_i;
    logic            coef_we;
    logic [2:0]      coef_idx;
    logic [CW-1:0]   coef_data;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   sum_o;
    logic            ovf_o;
    logic            busy_o;

    int total = 0;
    int bad   = 0;

    multiply_sum_pipe #(.NUM_TAPS(N), .DATA_W(DW), .COEF_W(CW), .BIAS_W(BW), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_i(data_i), .bias_i(bias_i), .coef_we(coef_we), .coef_idx(coef_idx),
        .coef_data(coef_data), .out_valid(out_valid), .out_ready(out_ready),
        .sum_o(sum_o), .ovf_o(ovf_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_coef(input logic [2:0] idx, input logic signed [7:0] val);
        coef_we   = 1'b1;
        coef_idx  = idx;
        coef_data = val;
        tick;
        coef_we   = 1'b0;
    endtask

    task automatic set_smp(input logic signed [31:0] a, input logic signed [31:0] b,
                           input logic signed [31:0] c, input logic signed [15:0] bias);
        data_i = {c, b, a};
        bias_i = bias;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_data = '0;
        out_ready = 1'b1; data_i = '0; bias_i = '0;
        tick;
        tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sum", sum_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // basic: 40 + 120 - 390 + 5
        wr_coef(0, 4); wr_coef(1, 6); wr_coef(2, -13);
        set_smp(10, 20, 30, 5); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("basic_busy", busy_o, 1);
        chk("basic_valid_n", out_valid, 0);
        tick;
        chk("basic_valid_n1", out_valid, 0);
        tick;
        chk("basic_valid_n2", out_valid, 1);
        chk("basic_sum", sum_o, -225);
        chk("basic_ovf", ovf_o, 0);
        tick;
        chk("basic_drain", out_valid, 0);

        // streaming
        wr_coef(0, 1); wr_coef(1, 1); wr_coef(2, 1);
        for (int i = 0; i < 10; i++) begin
            set_smp(i, i, i, 0); in_valid = 1'b1;
            chk("stream_in_ready", in_ready, 1);
            tick;
            if (i >= 2) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_sum", sum_o, 3 * (i - 2));
            end
        end
        in_valid = 1'b0;
        tick;
        chk("stream_tail8_valid", out_valid, 1);
        chk("stream_tail8", sum_o, 24);
        tick;
        chk("stream_tail9", sum_o, 27);
        tick;
        chk("stream_drain", out_valid, 0);

        // back-pressure with three in flight and a fourth held by the source
        out_ready = 1'b0;
        set_smp(1, 1, 1, 0); in_valid = 1'b1; tick;
        set_smp(2, 2, 2, 0); tick;
        set_smp(3, 3, 3, 0); tick;
        set_smp(4, 4, 4, 0);
        for (int c = 0; c < 4; c++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_hold", sum_o, 3);
            tick;
        end
        chk("bp_hold_end", sum_o, 3);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("bp_out2", sum_o, 6);
        tick;
        chk("bp_out3", sum_o, 9);
        tick;
        chk("bp_out4", sum_o, 12);
        tick;
        chk("bp_drain", out_valid, 0);

        // coefficient write racing an accept
        wr_coef(0, 4);
        set_smp(1, 0, 0, -3); in_valid = 1'b1;
        coef_we = 1'b1; coef_idx = 3'd0; coef_data = 8'sd2;
        tick;
        coef_we = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        chk("race_old_valid", out_valid, 1);
        chk("race_old", sum_o, 1);
        tick;
        chk("race_new", sum_o, -1);

        // out-of-range indices must not alias onto real taps: coef = {2,1,1}
        wr_coef(3, 50); wr_coef(4, 50); wr_coef(5, 50); wr_coef(6, 50); wr_coef(7, 50);
        set_smp(1, 1, 1, 0); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("idx_ignored", sum_o, 4);

        // full overflow: 381 * (2^31-1)
        wr_coef(0, 127); wr_coef(1, 127); wr_coef(2, 127);
        set_smp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("ovf_flag", ovf_o, 1);
        chk("ovf_sum", sum_o, SAT ? 32'h7FFF_FFFF : 32'h7FFF_FE83);

        // range edges with coef = {1,1,0}
        wr_coef(0, 1); wr_coef(1, 1); wr_coef(2, 0);
        in_valid = 1'b1;
        set_smp(32'h7FFF_FFFF, 0, 0, 0); tick;
        set_smp(32'h7FFF_FFFF, 1, 0, 0); tick;
        set_smp(32'h8000_0000, 0, 0, 0); tick;
        chk("edge_max_ovf", ovf_o, 0);
        chk("edge_max_sum", sum_o, 32'h7FFF_FFFF);
        set_smp(32'h8000_0000, -1, 0, 0); tick;
        in_valid = 1'b0;
        chk("edge_max1_ovf", ovf_o, 1);
        chk("edge_max1_sum", sum_o, SAT ? 32'h7FFF_FFFF : 32'h8000_0000);
        tick;
        chk("edge_min_ovf", ovf_o, 0);
        chk("edge_min_sum", sum_o, 32'h8000_0000);
        tick;
        chk("edge_min1_ovf", ovf_o, 1);
        chk("edge_min1_sum", sum_o, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF);
        tick;

        // reset with two samples in flight
        set_smp(1, 1, 1, 0); in_valid = 1'b1;
        tick;
        tick;
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy_o, 0);
        tick;
        chk("mid_rst_valid1", out_valid, 0);
        tick;
        chk("mid_rst_valid2", out_valid, 0);
        set_smp(5, 5, 5, 7); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_sum", sum_o, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiply_sum_pipe.md
Name: multiply_sum_pipe

Overview:
- Parametrised, handshaked successor to the fixed 3-input multiply-sum datapath.
- Computes out = bias + sum over k of (coef[k] * data[k]) for NUM_TAPS signed inputs.
- Coefficients are run-time programmable through a register write port.
- Three-stage pipeline with valid/ready flow control, full back-pressure, and overflow reporting; sits between the sample source and the downstream accumulator/output stage.

Parameters:
NUM_TAPS, 3, number of input taps (legal 2..8)
DATA_W, 32, signed width of each data tap
COEF_W, 8, signed width of each coefficient
BIAS_W, 16, signed width of bias input
OUT_W, 32, signed width of result

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  sample present on data_i/bias_i
in_ready  output  1  block can accept a sample this cycle
data_i  input  NUM_TAPS*DATA_W  tap k at bits [k*DATA_W +: DATA_W], signed
bias_i  input  BIAS_W  signed bias, sampled with data_i
coef_we  input  1  coefficient write strobe
coef_idx  input  3  coefficient index; writes with idx >= NUM_TAPS ignored
coef_data  input  COEF_W  signed coefficient value
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum_o  output  OUT_W  signed result
ovf_o  output  1  full-precision result outside OUT_W signed range; qualified by out_valid
busy_o  output  1  OR of all stage valid bits

Behaviour:
- Reset (rst=1 at edge): all stage valids=0, out_valid=0, sum_o=0, ovf_o=0, busy_o=0, all coefficients=0. Applies mid-operation: in-flight samples are discarded, never emitted.
- Internal width: ACC_W = DATA_W+COEF_W+clog2(NUM_TAPS)+1. All arithmetic is signed and full-precision in ACC_W; bias is sign-extended.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall (combinational). When stall=1 no stage register updates; when stall=0 all stages advance (bubbles collapse only via this global advance).
- Accept: in_valid & in_ready at an edge.
- S1 (accept edge): per-tap products coef[k]*data[k] and extended bias are registered; v1 <= accept.
- S2: products summed pairwise (adder tree, first level, odd tap passes through) plus bias into partials; v2 <= v1.
- S3: partials summed into full result R; sum_o = R reduced to OUT_W (see Optional Feature); ovf_o = (R > 2^(OUT_W-1)-1) or (R < -2^(OUT_W-1)); out_valid <= v2.
- Latency: sample accepted at edge N appears with out_valid=1 after edge N+2, absent stalls. Throughput: 1 sample/cycle.
- Output hold: while out_valid & ~out_ready, sum_o/ovf_o are stable.
- Coefficients: coef_we at an edge writes coef[coef_idx] <= coef_data, regardless of stall. A sample accepted on the same edge uses the old value. A sample accepted on any later edge uses the new value. Samples already past S1 are unaffected.
- in_valid with in_ready=0: nothing captured; the source must hold the sample.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro: MULTIPLY_SUM_PIPE_SATURATE_EN.
- Defined: on overflow, sum_o is clamped to 2^(OUT_W-1)-1 (positive) or -2^(OUT_W-1) (negative).
- Undefined: sum_o = R[OUT_W-1:0] (two's-complement wrap).
- ovf_o behaves identically in both builds.

Test Plan:
- Basic: defaults; coef={4,6,-13}; bias=5; data={10,20,30}; out_ready=1 -> out_valid 3 edges after accept, sum_o=-225, ovf_o=0.
- Streaming: 10 back-to-back samples with data={i,i,i}, coef={1,1,1}, bias=0 -> in_ready constantly 1; outputs 0,3,6,...,27 on consecutive cycles.
- Back-pressure: out_ready=0 for 4 cycles with 3 samples in flight -> in_ready=0; sum_o held stable; no loss or duplication; order preserved after release.
- Coef race: coef_we idx0 value 2 on the same edge as accepting data={1,0,0} (old coef0=4) -> result 4 (+bias); next sample data={1,0,0} -> result 2 (+bias).
- Overflow: coef={127,127,127}; data all 0x7FFFFFFF; bias=0 -> ovf_o=1; sum_o=0x7FFFFFFF with macro, R[31:0] without.
- Reset: assert rst for 1 cycle with 2 samples in flight -> no out_valid afterwards, coefs=0; next sample with data={5,5,5}, bias=7 -> sum_o=7.
